// File: rtl/io_input_controller.sv
// io_input_controller
// User-input front end: synchronises and debounces the push-buttons,
// exports debounced levels and press pulses, and sequences the core's IN
// instruction (stall, wait for a clean confirm press/release, capture the
// switch bank on the press, return it with a one-cycle acknowledge).
module io_input_controller #(
  parameter int                       NUM_BTN        = 4,
  parameter int                       CONFIRM_IDX    = 0,
  parameter int                       DATA_WIDTH     = 16,
  parameter int                       COUNTER_WIDTH  = 16,
  parameter logic [COUNTER_WIDTH-1:0] COUNTER_MAX    = 16'hFFFF,
  parameter bit                       BTN_ACTIVE_LOW = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_BTN-1:0]    btn_raw,
  input  logic [DATA_WIDTH-1:0] sw_raw,
  input  logic                  in_req,
  output logic                  in_ack,
  output logic [DATA_WIDTH-1:0] in_data,
  output logic                  stall,
  output logic [NUM_BTN-1:0]    btn_level,
  output logic [NUM_BTN-1:0]    btn_press
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE,
    ACK
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic                     capture;

  logic [NUM_BTN-1:0]       btn_in;
  logic [NUM_BTN-1:0]       btn_s1;
  logic [NUM_BTN-1:0]       btn_sync;
  logic [DATA_WIDTH-1:0]    sw_s1;
  logic [DATA_WIDTH-1:0]    sw_sync;
  logic [NUM_BTN-1:0]       btn_level_d;
  logic [COUNTER_WIDTH-1:0] cnt [NUM_BTN];

  // Normalise polarity so every internal signal reads 1 = pressed.
  assign btn_in = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

  // Two-flop synchronisers for the asynchronous button and switch pins.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value; blocking here would collapse the two stages.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1   <= '0;
      btn_sync <= '0;
      sw_s1    <= '0;
      sw_sync  <= '0;
    end else begin
      btn_s1   <= btn_in;
      btn_sync <= btn_s1;
      sw_s1    <= sw_raw;
      sw_sync  <= sw_s1;
    end
  end

  // Per-button debounce: accept a new level only after COUNTER_MAX+1
  // consecutive mismatching cycles; any matching cycle restarts the count.
  // NOTE: the counter array is cleared element by element in reset; it is a
  // handful of flops, not a RAM, and must start from a known zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_level <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (btn_sync[i] == btn_level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == COUNTER_MAX) begin
          btn_level[i] <= btn_sync[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Registered rising-edge detect on the debounced levels; releases give no pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_level_d <= '0;
      btn_press   <= '0;
    end else begin
      btn_level_d <= btn_level;
      btn_press   <= btn_level & ~btn_level_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state and outputs. A press pulse seen in IDLE is deliberately
  // ignored, so a button already down when the request arrives cannot confirm.
  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    stall      = 1'b0;
    in_ack     = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_req) state_next = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        stall = 1'b1;
        if (!in_req) begin
          state_next = IDLE;
        end else if (btn_press[CONFIRM_IDX]) begin
          capture    = 1'b1;
          state_next = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        // No abort once the value is captured; only the release matters.
        stall = 1'b1;
        if (!btn_level[CONFIRM_IDX]) state_next = ACK;
      end
      ACK: begin
        in_ack     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the synchronised switch bank on the confirming press.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     in_data <= '0;
    else if (capture) in_data <= sw_sync;
  end

endmodule

// File: tb/tb_io_input_controller.sv
// Directed bench for io_input_controller with COUNTER_MAX=4 and active-high
// buttons. Inputs change 1 ns after a rising edge; outputs are sampled there.
module tb_io_input_controller;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  btn_raw = '0;
  logic [15:0] sw_raw = '0;
  logic        in_req = 1'b0;
  logic        in_ack;
  logic [15:0] in_data;
  logic        stall;
  logic [3:0]  btn_level;
  logic [3:0]  btn_press;

  int checks = 0;
  int errors = 0;

  io_input_controller #(
    .NUM_BTN       (4),
    .CONFIRM_IDX   (0),
    .DATA_WIDTH    (16),
    .COUNTER_WIDTH (16),
    .COUNTER_MAX   (16'd4),
    .BTN_ACTIVE_LOW(1'b0)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .btn_raw  (btn_raw),
    .sw_raw   (sw_raw),
    .in_req   (in_req),
    .in_ack   (in_ack),
    .in_data  (in_data),
    .stall    (stall),
    .btn_level(btn_level),
    .btn_press(btn_press)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] btn;
    logic       req;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic       stl;
    logic       ack;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  int   presses;
  int   acks;
  bit   lvl_seen;
  bit   bad;
  logic pat [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    // Clean press and release of button 1, one record per clock edge.
    for (int i = 0; i < 6; i++) vecs.push_back('{4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0});
    vecs.push_back('{4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0});   // edge +7: level rises
    vecs.push_back('{4'b0010, 1'b0, 4'b0010, 4'b0010, 1'b0, 1'b0});   // edge +8: press pulse
    vecs.push_back('{4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0});   // edge +9: pulse gone
    for (int i = 0; i < 6; i++) vecs.push_back('{4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0});
    vecs.push_back('{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0});   // release accepted, no pulse
    vecs.push_back('{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0});

    // Reset state.
    #3;
    check("reset_outputs", {in_ack, stall, in_data, btn_level, btn_press}, 32'h0);
    #9 reset_n = 1'b1;

    foreach (vecs[i]) begin
      btn_raw = vecs[i].btn;
      in_req  = vecs[i].req;
      step();
      check($sformatf("vec%0d", i), {btn_level, btn_press, stall, in_ack},
            {vecs[i].lvl, vecs[i].prs, vecs[i].stl, vecs[i].ack});
    end

    // Bounce on button 0: pulses of 2 cycles never reach the threshold.
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0;
    presses = 0;
    lvl_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      btn_raw[0] = pat[i];
      repeat (2) begin
        step();
        if (btn_press[0]) presses++;
        if (btn_level[0]) lvl_seen = 1'b1;
      end
    end
    check("bounce_no_level", 32'(lvl_seen), 32'd0);
    btn_raw[0] = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      step();
      if (btn_press[0]) presses++;
      if (j == 6) check("bounce_level_t6", 32'(btn_level[0]), 32'd0);
      if (j == 7) check("bounce_level_t7", 32'(btn_level[0]), 32'd1);
    end
    check("bounce_press_count", presses, 1);
    btn_raw[0] = 1'b0;
    repeat (10) step();
    check("bounce_released", 32'(btn_level), 32'h0);

    // Full IN transaction.
    sw_raw = 16'hA5C3;
    in_req = 1'b1;
    step();
    check("in_stall_on_req", 32'(stall), 32'd1);
    btn_raw[0] = 1'b1;
    bad = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      step();
      if (!stall || in_ack) bad = 1'b1;
    end
    check("in_press_stall", 32'(bad), 32'd0);
    check("in_press_level", 32'(btn_level[0]), 32'd1);
    step();
    check("in_press_pulse", {btn_press, in_data}, {4'b0001, 16'h0000});
    step();
    check("in_capture", {stall, in_data}, {1'b1, 16'hA5C3});
    btn_raw[0] = 1'b0;
    bad = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      step();
      if (!stall || in_ack) bad = 1'b1;
    end
    check("in_release_stall", 32'(bad), 32'd0);
    check("in_release_level", 32'(btn_level[0]), 32'd0);
    step();
    check("in_ack_cycle", {in_ack, stall}, {1'b1, 1'b0});
    in_req = 1'b0;
    step();
    check("in_after_ack", {in_ack, stall, in_data}, {1'b0, 1'b0, 16'hA5C3});

    // Abort: request dropped while waiting for the press.
    acks = 0;
    in_req = 1'b1;
    step();
    check("abort_stall", 32'(stall), 32'd1);
    repeat (3) begin
      step();
      if (in_ack) acks++;
    end
    in_req = 1'b0;
    step();
    if (in_ack) acks++;
    repeat (3) begin
      step();
      if (in_ack) acks++;
    end
    check("abort_idle", {stall, in_data}, {1'b0, 16'hA5C3});
    check("abort_no_ack", acks, 0);

    // Button held before the request must not confirm.
    btn_raw[0] = 1'b1;
    sw_raw = 16'h1234;
    repeat (10) step();
    in_req = 1'b1;
    step();
    check("held_stall", 32'(stall), 32'd1);
    repeat (10) step();
    check("held_no_capture", {stall, in_ack, in_data}, {1'b1, 1'b0, 16'hA5C3});
    btn_raw[0] = 1'b0;
    repeat (9) step();
    check("held_released", {btn_level[0], stall, in_data}, {1'b0, 1'b1, 16'hA5C3});
    btn_raw[0] = 1'b1;
    repeat (8) step();
    check("repress_pulse", 32'(btn_press), 32'h1);
    step();
    check("repress_capture", {stall, in_data}, {1'b1, 16'h1234});
    in_req = 1'b0;
    repeat (2) step();
    check("release_ignores_req", {stall, in_ack}, {1'b1, 1'b0});

    // Reset in WAIT_RELEASE.
    reset_n = 1'b0;
    btn_raw = '0;
    #2;
    check("midreset_outputs", {in_ack, stall, in_data, btn_level, btn_press}, 32'h0);
    repeat (2) step();
    reset_n = 1'b1;
    acks = 0;
    bad = 1'b0;
    repeat (20) begin
      step();
      if (in_ack) acks++;
      if (stall) bad = 1'b1;
    end
    check("midreset_no_ack", acks, 0);
    check("midreset_idle", {bad, in_data}, {1'b0, 16'h0000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
